// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory access stage.
package mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } mem_state_t;

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the access stage (master) and memory (slave).
// D_REQ is a valid: once raised, D_WEN/D_BE/D_ADDR/D_DOUT stay stable until the cycle D_ACK=1 completes it.
interface mem_access_stage_if #(
  parameter int ADDR_W = 12
);
  logic              D_REQ;
  logic              D_WEN;
  logic [3:0]        D_BE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [31:0]       D_DOUT;
  logic [31:0]       D_DIN;
  logic              D_ACK;

  modport master (
    output D_REQ, D_WEN, D_BE, D_ADDR, D_DOUT,
    input  D_DIN, D_ACK
  );

  modport slave (
    input  D_REQ, D_WEN, D_BE, D_ADDR, D_DOUT,
    output D_DIN, D_ACK
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-enable generation, store lane replication and load extraction/extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_value,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_value
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = load_data >> {addr_lo, 3'b000};
    be         = 4'b1111;
    store_data = store_value;
    load_value = load_data;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        store_data = {4{store_value[7:0]}};
        load_value = (funct3 == F3_BU) ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << addr_lo;
        store_data = {2{store_value[15:0]}};
        load_value = (funct3 == F3_HU) ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores, stalls the front of the pipe while a request is outstanding.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_MAX = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                valid_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [31:0]         aluResult_i,
  input  logic [31:0]         storeValue_i,
  input  logic [4:0]          rd_i,
  input  logic                flush_i,
  mem_access_stage_if.master  dmem,
  output logic [31:0]         aluResult_o,
  output logic [4:0]          rd_o,
  output logic [31:0]         memReadValue_o,
  output logic                valid_o,
  output logic                stall_o,
  output logic                err_o,
  output mem_state_t          state
);

  localparam logic [7:0] CNT_MAX = 8'(WAIT_MAX);

  mem_state_t        state_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wen;
  logic [3:0]        lat_be;
  logic [31:0]       lat_dout;
  logic [2:0]        lat_funct3;

  logic        is_load, is_store, mem_op, bad_align, issue, timeout, in_idle;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_store, al_load;
  logic        load_sel;

  assign is_load   = (opcode_i == OPC_LOAD);
  assign is_store  = (opcode_i == OPC_STORE);
  assign mem_op    = valid_i & ~flush_i & (is_load | is_store);
  assign bad_align = misaligned(funct3_i, aluResult_i[1:0]);
  assign issue     = mem_op & ~bad_align;
  assign in_idle   = (state_q == ST_IDLE);
  assign timeout   = ~in_idle & (cnt_q == CNT_MAX);

  // Once a request is outstanding, extraction follows the latched access, not the live inputs.
  assign al_funct3 = in_idle ? funct3_i : lat_funct3;
  assign al_addr   = in_idle ? aluResult_i[1:0] : lat_addr[1:0];

  lsu_align u_align (
    .funct3      (al_funct3),
    .addr_lo     (al_addr),
    .store_value (storeValue_i),
    .load_data   (dmem.D_DIN),
    .be          (al_be),
    .store_data  (al_store),
    .load_value  (al_load)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lat_addr   <= '0;
      lat_wen    <= 1'b0;
      lat_be     <= '0;
      lat_dout   <= '0;
      lat_funct3 <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue && !dmem.D_ACK) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            lat_addr   <= aluResult_i[ADDR_W-1:0];
            lat_wen    <= is_store;
            lat_be     <= al_be;
            lat_dout   <= is_store ? al_store : '0;
            lat_funct3 <= funct3_i;
          end
        end
        ST_WAIT: begin
          if (timeout || dmem.D_ACK) begin
            state_q <= ST_IDLE;
          end else if (flush_i) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (timeout || dmem.D_ACK) state_q <= ST_IDLE;
          else cnt_q <= cnt_q + 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dmem.D_REQ  = 1'b0;
    dmem.D_WEN  = 1'b0;
    dmem.D_BE   = '0;
    dmem.D_ADDR = '0;
    dmem.D_DOUT = '0;
    valid_o     = 1'b0;
    stall_o     = 1'b0;
    err_o       = 1'b0;
    load_sel    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (bad_align) begin
            err_o = 1'b1;
          end else begin
            dmem.D_REQ  = 1'b1;
            dmem.D_WEN  = is_store;
            dmem.D_BE   = al_be;
            dmem.D_ADDR = {aluResult_i[ADDR_W-1:2], 2'b00};
            dmem.D_DOUT = is_store ? al_store : '0;
            valid_o     = dmem.D_ACK;
            stall_o     = ~dmem.D_ACK;
            load_sel    = is_load;
          end
        end else begin
          valid_o = valid_i & ~flush_i;
        end
      end
      ST_WAIT, ST_DRAIN: begin
        if (timeout) begin
          err_o = 1'b1;
        end else begin
          dmem.D_REQ  = 1'b1;
          dmem.D_WEN  = lat_wen;
          dmem.D_BE   = lat_be;
          dmem.D_ADDR = {lat_addr[ADDR_W-1:2], 2'b00};
          dmem.D_DOUT = lat_dout;
          stall_o     = ~dmem.D_ACK;
          // A flush arriving together with the ack still kills the result.
          valid_o     = (state_q == ST_WAIT) & dmem.D_ACK & ~flush_i;
          load_sel    = ~lat_wen;
        end
      end
      default: ;
    endcase
    // Reset drops the request and handshake outputs without waiting for a clock edge.
    if (RST) begin
      dmem.D_REQ = 1'b0;
      valid_o    = 1'b0;
      stall_o    = 1'b0;
      err_o      = 1'b0;
    end
  end

  assign memReadValue_o = (valid_o && load_sel) ? al_load : '0;
  assign aluResult_o    = aluResult_i;
  assign rd_o           = rd_i;
  assign state          = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: memory handshake driven step by step, load results scoreboarded.
module tb_mem_access_stage;
  import mem_pkg::*;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        CLK, RST;
  logic        valid_i, flush_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] aluResult_i, storeValue_i;
  logic [4:0]  rd_i;
  logic [31:0] aluResult_o, memReadValue_o;
  logic [4:0]  rd_o;
  logic        valid_o, stall_o, err_o;
  mem_state_t  state;

  mem_access_stage_if #(.ADDR_W(12)) dmem ();

  mem_access_stage #(.ADDR_W(12), .WAIT_MAX(255)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .valid_i        (valid_i),
    .opcode_i       (opcode_i),
    .funct3_i       (funct3_i),
    .aluResult_i    (aluResult_i),
    .storeValue_i   (storeValue_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .dmem           (dmem.master),
    .aluResult_o    (aluResult_o),
    .rd_o           (rd_o),
    .memReadValue_o (memReadValue_o),
    .valid_o        (valid_o),
    .stall_o        (stall_o),
    .err_o          (err_o),
    .state          (state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int wait_n;
  logic hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed result with empty queue expected queued value", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, memReadValue_o, e);
    end
  endtask

  // driver: one cycle of inputs, applied at the falling edge, outputs settled 1 ns later
  task automatic cyc(input logic v, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sv, input logic [4:0] rd,
                     input logic fl, input logic ack, input logic [31:0] din);
    @(negedge CLK);
    valid_i      = v;
    opcode_i     = op;
    funct3_i     = f3;
    aluResult_i  = addr;
    storeValue_i = sv;
    rd_i         = rd;
    flush_i      = fl;
    dmem.D_ACK   = ack;
    dmem.D_DIN   = din;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    RST = 1'b0;
    valid_i = 1'b0; opcode_i = '0; funct3_i = '0; aluResult_i = '0;
    storeValue_i = '0; rd_i = '0; flush_i = 1'b0;
    dmem.D_ACK = 1'b0; dmem.D_DIN = '0;
    #2 RST = 1'b1;

    // reset state
    @(negedge CLK); #1;
    check("rst_req", dmem.D_REQ, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge CLK);
    RST = 1'b0;

    // stray ack with nothing outstanding
    cyc(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h1234_5678);
    check("stray_ack_valid", valid_o, 1'b0);
    check("stray_ack_req", dmem.D_REQ, 1'b0);
    idle_cyc();
    check("stray_ack_state", 32'(state), 32'(ST_IDLE));

    // non-memory passthrough, then flushed
    cyc(1'b1, OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd7, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("alu_valid", valid_o, 1'b1);
    check("alu_req", dmem.D_REQ, 1'b0);
    check("alu_result", aluResult_o, 32'h0000_1234);
    check("alu_rd", 32'(rd_o), 32'd7);
    check("alu_memread", memReadValue_o, 32'h0);
    check("alu_stall", stall_o, 1'b0);
    cyc(1'b1, OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    check("alu_flush_valid", valid_o, 1'b0);

    // LW zero-latency
    exp_q.push_back(32'hDEAD_BEEF);
    cyc(1'b1, OP_LD, F3_W, 32'h010, 32'h0, 5'd3, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("lw0_req", dmem.D_REQ, 1'b1);
    check("lw0_wen", dmem.D_WEN, 1'b0);
    check("lw0_addr", 32'(dmem.D_ADDR), 32'h010);
    check("lw0_be", 32'(dmem.D_BE), 32'hF);
    check("lw0_stall", stall_o, 1'b0);
    check("lw0_valid", valid_o, 1'b1);
    sb_check("lw0_data");

    // LB at 0x013, ack after 3 stalled cycles; live address wiggles while waiting
    exp_q.push_back(32'hFFFF_FF80);
    cyc(1'b1, OP_LD, F3_B, 32'h013, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0);
    check("lb_req", dmem.D_REQ, 1'b1);
    check("lb_be", 32'(dmem.D_BE), 32'h8);
    check("lb_addr", 32'(dmem.D_ADDR), 32'h010);
    check("lb_stall_c1", stall_o, 1'b1);
    check("lb_valid_c1", valid_o, 1'b0);
    for (int i = 2; i <= 3; i++) begin
      cyc(1'b1, OP_LD, F3_B, 32'h0FC, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0);
      check("lb_stall_wait", stall_o, 1'b1);
      check("lb_valid_wait", valid_o, 1'b0);
      check("lb_addr_held", 32'(dmem.D_ADDR), 32'h010);
      check("lb_state_wait", 32'(state), 32'(ST_WAIT));
    end
    cyc(1'b1, OP_LD, F3_B, 32'h0FC, 32'h0, 5'd4, 1'b0, 1'b1, 32'h80FF_0000);
    check("lb_stall_ack", stall_o, 1'b0);
    check("lb_valid_ack", valid_o, 1'b1);
    sb_check("lb_data");
    idle_cyc();
    check("lb_state_back", 32'(state), 32'(ST_IDLE));

    // SH at 0x006, one wait cycle; store value changes while waiting
    exp_q.push_back(32'h0);
    cyc(1'b1, OP_ST, F3_H, 32'h006, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 32'h0);
    check("sh_be", 32'(dmem.D_BE), 32'hC);
    check("sh_dout", dmem.D_DOUT, 32'h1234_1234);
    check("sh_wen", dmem.D_WEN, 1'b1);
    check("sh_addr", 32'(dmem.D_ADDR), 32'h004);
    check("sh_stall", stall_o, 1'b1);
    cyc(1'b1, OP_ST, F3_H, 32'h006, 32'h0000_FFFF, 5'd0, 1'b0, 1'b1, 32'h0);
    check("sh_dout_held", dmem.D_DOUT, 32'h1234_1234);
    check("sh_be_held", 32'(dmem.D_BE), 32'hC);
    check("sh_valid_ack", valid_o, 1'b1);
    sb_check("sh_memread_zero");

    // SB / SW lane replication, same-cycle ack
    cyc(1'b1, OP_ST, F3_B, 32'h001, 32'h0000_00AB, 5'd0, 1'b0, 1'b1, 32'h0);
    check("sb_be", 32'(dmem.D_BE), 32'h2);
    check("sb_dout", dmem.D_DOUT, 32'hABAB_ABAB);
    cyc(1'b1, OP_ST, F3_W, 32'h008, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 32'h0);
    check("sw_be", 32'(dmem.D_BE), 32'hF);
    check("sw_dout", dmem.D_DOUT, 32'hCAFE_F00D);

    // load extension variants
    exp_q.push_back(32'h0000_8001);
    cyc(1'b1, OP_LD, F3_HU, 32'h002, 32'h0, 5'd5, 1'b0, 1'b1, 32'h8001_0000);
    sb_check("lhu_data");
    exp_q.push_back(32'hFFFF_8001);
    cyc(1'b1, OP_LD, F3_H, 32'h002, 32'h0, 5'd5, 1'b0, 1'b1, 32'h8001_0000);
    sb_check("lh_data");
    exp_q.push_back(32'h0000_009A);
    cyc(1'b1, OP_LD, F3_BU, 32'h001, 32'h0, 5'd5, 1'b0, 1'b1, 32'h0000_9A00);
    sb_check("lbu_data");

    // misaligned accesses
    cyc(1'b1, OP_LD, F3_W, 32'h002, 32'h0, 5'd6, 1'b0, 1'b0, 32'h0);
    check("mis_lw_req", dmem.D_REQ, 1'b0);
    check("mis_lw_err", err_o, 1'b1);
    check("mis_lw_valid", valid_o, 1'b0);
    check("mis_lw_stall", stall_o, 1'b0);
    idle_cyc();
    check("mis_lw_err_pulse", err_o, 1'b0);
    cyc(1'b1, OP_ST, F3_H, 32'h001, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    check("mis_sh_err", err_o, 1'b1);
    check("mis_sh_req", dmem.D_REQ, 1'b0);

    // flush while outstanding: LW, flush in 2nd cycle, ack in 4th
    cyc(1'b1, OP_LD, F3_W, 32'h020, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0);
    check("fl_c1_valid", valid_o, 1'b0);
    check("fl_c1_stall", stall_o, 1'b1);
    cyc(1'b1, OP_LD, F3_W, 32'h020, 32'h0, 5'd8, 1'b1, 1'b0, 32'h0);
    check("fl_c2_valid", valid_o, 1'b0);
    check("fl_c2_stall", stall_o, 1'b1);
    check("fl_c2_req", dmem.D_REQ, 1'b1);
    cyc(1'b1, OP_LD, F3_W, 32'h020, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0);
    check("fl_c3_state", 32'(state), 32'(ST_DRAIN));
    check("fl_c3_valid", valid_o, 1'b0);
    check("fl_c3_stall", stall_o, 1'b1);
    check("fl_c3_req", dmem.D_REQ, 1'b1);
    cyc(1'b1, OP_LD, F3_W, 32'h020, 32'h0, 5'd8, 1'b0, 1'b1, 32'h1111_2222);
    check("fl_c4_valid", valid_o, 1'b0);
    check("fl_c4_stall", stall_o, 1'b0);
    idle_cyc();
    check("fl_c5_state", 32'(state), 32'(ST_IDLE));
    check("fl_c5_stall", stall_o, 1'b0);

    // timeout: 255 waiting cycles after issue, then err with the request dropped
    cyc(1'b1, OP_LD, F3_W, 32'h030, 32'h0, 5'd9, 1'b0, 1'b0, 32'h0);
    check("to_issue_stall", stall_o, 1'b1);
    wait_n = 0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge CLK); #1;
      if (err_o) hit = 1'b1;
      else if (dmem.D_REQ) wait_n++;
    end
    check("to_seen", hit, 1'b1);
    check("to_wait_cycles", wait_n, 32'd255);
    check("to_req", dmem.D_REQ, 1'b0);
    check("to_valid", valid_o, 1'b0);
    check("to_stall", stall_o, 1'b0);
    idle_cyc();
    check("to_state", 32'(state), 32'(ST_IDLE));
    check("to_err_pulse", err_o, 1'b0);

    // reset mid-WAIT drops the request without a clock edge
    cyc(1'b1, OP_LD, F3_W, 32'h040, 32'h0, 5'd10, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, OP_LD, F3_W, 32'h040, 32'h0, 5'd10, 1'b0, 1'b0, 32'h0);
    check("rw_req_before", dmem.D_REQ, 1'b1);
    #1 RST = 1'b1;
    #1;
    check("rw_req_dropped", dmem.D_REQ, 1'b0);
    check("rw_stall", stall_o, 1'b0);
    check("rw_state", 32'(state), 32'(ST_IDLE));
    idle_cyc();
    RST = 1'b0;

    // normal access after reset
    exp_q.push_back(32'h0BAD_F00D);
    cyc(1'b1, OP_LD, F3_W, 32'h044, 32'h0, 5'd11, 1'b0, 1'b1, 32'h0BAD_F00D);
    check("post_rst_valid", valid_o, 1'b1);
    sb_check("post_rst_data");
    idle_cyc();

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
